fir_mac_seq: RTL

Multi-channel, time-multiplexed FIR filter. It uses one signed multiplier-accumulator, runtime-loadable double-buffered coefficients, and valid/ready handshakes on both input and output. It generalises the fixed single-channel, fully parallel FIR to CHANNELS independent delay lines sharing one MAC, with saturating output scaling. It sits between the ADC capture path and the decimator/trigger logic in the analogue front end.

---
 rtl/fir_mac_seq_if.sv | 38 +++
 rtl/fir_mac_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq_if.sv
// Sample, result and coefficient-load bus of the time-multiplexed FIR.
// The slave modport is the filter side, the master modport the driver side.
interface fir_mac_seq_if #(
  parameter int unsigned N           = 16,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned X_WIDTH     = 12,
  parameter int unsigned Y_WIDTH     = 12,
  parameter int unsigned COEFF_WIDTH = 16
);
  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned ADDR_W = (N > 1) ? $clog2(N) : 1;

  logic                          in_valid;
  logic                          in_ready;
  logic [CH_W-1:0]               in_ch;
  logic signed [X_WIDTH-1:0]     x;
  logic                          out_valid;
  logic                          out_ready;
  logic [CH_W-1:0]               out_ch;
  logic signed [Y_WIDTH-1:0]     y;
  logic                          coeff_we;
  logic [ADDR_W-1:0]             coeff_addr;
  logic signed [COEFF_WIDTH-1:0] coeff_data;
  logic                          coeff_swap;
  logic                          swap_pending;

  modport slave (
    input  in_valid, in_ch, x, out_ready,
    input  coeff_we, coeff_addr, coeff_data, coeff_swap,
    output in_ready, out_valid, out_ch, y, swap_pending
  );

  modport master (
    output in_valid, in_ch, x, out_ready,
    output coeff_we, coeff_addr, coeff_data, coeff_swap,
    input  in_ready, out_valid, out_ch, y, swap_pending
  );
endinterface

// File: rtl/fir_mac_seq.sv
// Multi-channel time-multiplexed FIR: one signed MAC shared by CHANNELS
// circular delay lines, double-buffered coefficients, saturating output.
// Optional macro FIR_MAC_SEQ_ROUND_EN: round half toward +inf before the
// output shift (default build truncates toward -inf).
module fir_mac_seq #(
  parameter int unsigned N           = 16,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned X_WIDTH     = 12,
  parameter int unsigned Y_WIDTH     = 12,
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned SHIFT       = 15
) (
  input logic          clk,
  input logic          rst,
  fir_mac_seq_if.slave bus
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned AW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned P_W  = X_WIDTH + COEFF_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] Y_MAX =
    ACC_WIDTH'({1'b0, {(Y_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] Y_MIN = ~Y_MAX;

`ifdef FIR_MAC_SEQ_ROUND_EN
  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] RND =
    (SHIFT > 0) ? (ACC_WIDTH'(1) << RND_SH) : '0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t state, state_next;

  // Datapath storage
  logic signed [X_WIDTH-1:0]     z_q      [CHANNELS][N];
  logic [AW-1:0]                 ptr_q    [CHANNELS];
  logic signed [COEFF_WIDTH-1:0] shadow_q [N];
  logic signed [COEFF_WIDTH-1:0] active_q [N];
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic [AW-1:0]                 k_q;
  logic [CH_W-1:0]               ch_q;
  logic                          swap_pending_q;

  // Registered outputs and their next values
  logic                      out_valid_q, out_valid_d;
  logic signed [Y_WIDTH-1:0] y_q, y_d;
  logic [CH_W-1:0]           out_ch_q, out_ch_d;

  // Control strobes
  logic          idle_c;
  logic          accept_c;
  logic          ch_ok_c;
  logic          mac_last_c;
  logic          copy_c;
  logic [AW-1:0] ptr_rd_c;
  logic [AW-1:0] tap_idx_c;
  logic signed [X_WIDTH-1:0]     z_rd_c;
  logic signed [COEFF_WIDTH-1:0] h_rd_c;
  logic signed [P_W-1:0]         prod_c;

  // Shift, optional round, and clamp the accumulator to the output range
  function automatic logic signed [Y_WIDTH-1:0] scale_sat(
    input logic signed [ACC_WIDTH-1:0] a
  );
    logic signed [ACC_WIDTH-1:0] r;
    r = a;
`ifdef FIR_MAC_SEQ_ROUND_EN
    if (SHIFT > 0) r = (a > ACC_MAX - RND) ? ACC_MAX : a + RND;
`endif
    r = r >>> SHIFT;
    if (r > Y_MAX)      r = Y_MAX;
    else if (r < Y_MIN) r = Y_MIN;
    return Y_WIDTH'(r);
  endfunction

  assign idle_c        = (state == ST_IDLE);
  assign bus.in_ready  = idle_c && !rst;
  assign accept_c      = bus.in_valid && bus.in_ready;
  assign ch_ok_c       = (32'(bus.in_ch) < CHANNELS);
  assign mac_last_c    = (state == ST_MAC) && (k_q == AW'(N - 1));
  assign copy_c        = idle_c && swap_pending_q;

  // Tap read address: newest sample minus k, modulo N
  always_comb begin
    ptr_rd_c  = ptr_q[ch_q];
    tap_idx_c = '0;
    if (ptr_rd_c >= k_q) tap_idx_c = ptr_rd_c - k_q;
    else                 tap_idx_c = AW'(32'(ptr_rd_c) + N - 32'(k_q));
    z_rd_c = z_q[ch_q][tap_idx_c];
    h_rd_c = active_q[k_q];
    prod_c = P_W'(z_rd_c) * P_W'(h_rd_c);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept_c && ch_ok_c) state_next = ST_MAC;
      ST_MAC:  if (mac_last_c) state_next = ST_OUT;
      ST_OUT:  if (out_valid_q && bus.out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output next values: present the result one cycle into OUT, hold until taken
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    out_ch_d    = out_ch_q;
    if (state == ST_OUT) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        y_d         = scale_sat(acc_q);
        out_ch_d    = ch_q;
      end else if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.y            = y_q;
  assign bus.out_ch       = out_ch_q;
  assign bus.swap_pending = swap_pending_q;

  // Delay lines, pointers, tap counter and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        ptr_q[c] <= '0;
        for (int i = 0; i < int'(N); i++) z_q[c][i] <= '0;
      end
      acc_q <= '0;
      k_q   <= '0;
      ch_q  <= '0;
    end else begin
      if (accept_c && ch_ok_c) begin
        z_q[bus.in_ch][ptr_q[bus.in_ch]] <= bus.x;
        ch_q  <= bus.in_ch;
        acc_q <= '0;
        k_q   <= '0;
      end else if (state == ST_MAC) begin
        acc_q <= acc_q + ACC_WIDTH'(prod_c);
        if (mac_last_c) begin
          k_q         <= '0;
          ptr_q[ch_q] <= (ptr_rd_c == AW'(N - 1)) ? '0 : ptr_rd_c + AW'(1);
        end else begin
          k_q <= k_q + AW'(1);
        end
      end
    end
  end

  // Coefficient banks: shadow written any time, copied to active only in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      swap_pending_q <= 1'b0;
    end else begin
      if (bus.coeff_we && (32'(bus.coeff_addr) < N))
        shadow_q[bus.coeff_addr] <= bus.coeff_data;
      if (copy_c)
        for (int i = 0; i < int'(N); i++) active_q[i] <= shadow_q[i];
      swap_pending_q <= bus.coeff_swap || (swap_pending_q && !copy_c);
    end
  end

endmodule
